mpu_bus_adapter: RTL and testbench
==================================

MPU_BUS_ADAPTER -- requirements
Module: mpu_bus_adapter

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchroniser flops on every external input (legal values >= 2).
REQ-002 SHALL have parameter RD_LATENCY, default 1, core read latency in clk cycles from mpu_en&mpu_rd to valid mpu_data_in (legal values >= 1).
REQ-003 SHALL have port clk, input, 1, system clock; this is the only clock.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port ext_ale, input, 1, async address latch enable from the 8-bit MCU; address is transparent while high.
REQ-006 SHALL have port ext_rd_n, input, 1, async read strobe, active low.
REQ-007 SHALL have port ext_wr_n, input, 1, async write strobe, active low.
REQ-008 SHALL have port ext_ad_in, input, 8, multiplexed A[7:0]/D[7:0] from the MCU.
REQ-009 SHALL have port ext_addr_hi, input, 8, A[15:8] from the MCU.
REQ-010 SHALL have port ext_data_out, output, 8, read byte driven toward the MCU.
REQ-011 SHALL have port ext_data_oe, output, 1, tristate enable for ext_data_out.
REQ-012 SHALL have ports mpu_en, mpu_rd and mpu_wr, each output, 1, core access strobes, active high.
REQ-013 SHALL have port mpu_be, output, 2, core byte enables.
REQ-014 SHALL have port mpu_addr, output, 16, core word address.
REQ-015 SHALL have port mpu_data_out, output, 16, write data to the core.
REQ-016 SHALL have port mpu_data_in, input, 16, read data from the core.
REQ-017 SHALL have port bus_err, output, 1, sticky flag for a protocol violation.

Function
REQ-018 SHALL pass ext_ale, ext_rd_n, ext_wr_n, ext_ad_in and ext_addr_hi through SYNC_STAGES flops each, so all synchronised copies (suffix _s) are mutually aligned.
REQ-019 SHALL load the 16-bit latched address A = {addr_hi_s, ad_s} every cycle ale_s=1 and hold it while ale_s=0.
REQ-020 SHALL drive mpu_addr = {1'b0, A[15:1]}; mpu_be = 2'b01 when A[0]=0 and 2'b10 when A[0]=1; mpu_data_out = {byte, byte}.
REQ-021 SHALL implement a state machine with states IDLE, RD_ISSUE, RD_CAPTURE, RD_HOLD, WR_SETTLE, WR_ISSUE and WR_DONE.
REQ-022 In IDLE with rd_s=0, wr_s=1 and ale_s=0, SHALL go to RD_ISSUE.
REQ-023 In IDLE with wr_s=0, rd_s=1 and ale_s=0, SHALL go to WR_SETTLE.
REQ-024 In RD_ISSUE, SHALL assert mpu_en=mpu_rd=1 for exactly RD_LATENCY cycles, then go to RD_CAPTURE.
REQ-025 In RD_CAPTURE, SHALL register ext_data_out = A[0] ? mpu_data_in[15:8] : mpu_data_in[7:0], set ext_data_oe=1 and go to RD_HOLD.
REQ-026 In RD_HOLD, SHALL keep ext_data_oe=1 and ext_data_out stable until rd_s=1, then go to IDLE with ext_data_oe=0 on the next cycle.
REQ-027 In WR_SETTLE (one cycle), SHALL capture ad_s into the write-data register.
REQ-028 In WR_ISSUE, SHALL assert mpu_en=mpu_wr=1 for exactly one cycle with the captured data, then go to WR_DONE.
REQ-029 In WR_DONE, SHALL wait for wr_s=1, then go to IDLE.
REQ-030 SHALL issue exactly one core access per MCU strobe, however long the strobe is held.
REQ-031 SHALL never assert mpu_rd and mpu_wr in the same cycle, and SHALL hold mpu_en=mpu_rd=mpu_wr=0 in all other states.
REQ-032 SHALL hold mpu_addr and mpu_be stable from issue until the state machine returns to IDLE.
REQ-033 If rd_s=0 and wr_s=0 in IDLE, SHALL stay in IDLE, issue no access and set bus_err=1.
REQ-034 If the opposite strobe falls during any read or write state, SHALL set bus_err=1 and finish the current transaction unchanged.
REQ-035 If ale_s=1 while a strobe is low in IDLE, SHALL wait in IDLE until ale_s=0.
REQ-036 SHALL clear bus_err only by reset.
REQ-037 Worst-case latency from the ext_rd_n fall to ext_data_oe=1 SHALL be SYNC_STAGES+RD_LATENCY+2 cycles, which is 5 cycles at default parameters.

Reset
REQ-038 When reset=1 at a clk edge, SHALL force state IDLE and set mpu_en=mpu_rd=mpu_wr=0, mpu_be=0, mpu_addr=0, mpu_data_out=0, ext_data_out=0, ext_data_oe=0 and bus_err=0, and clear all synchroniser flops to the idle level (strobes=1, ale=0, data=0).
REQ-039 A reset asserted mid-transaction SHALL abort it with no further core strobe; a strobe still held low after reset releases SHALL be treated as a new transaction.

Verification
REQ-040 Write scenario: ALE with A=0x1235, then ext_wr_n low for 8 cycles with ad=0xA5 -> exactly one cycle with mpu_wr=1, mpu_addr=0x091A, mpu_be=2'b10, mpu_data_out=0xA5A5.
REQ-041 Read scenario: A=0x2000, core returns 0xBEEF, ext_rd_n low -> mpu_rd high for 1 cycle, then ext_data_oe=1 with ext_data_out=0xEF within 5 cycles, held until 1 cycle after rd_s rises.
REQ-042 Odd-byte read scenario: A=0x2001 with the same core data -> ext_data_out=0xBE.
REQ-043 Long strobe scenario: ext_rd_n held low for 50 cycles -> only one mpu_en pulse train (RD_LATENCY cycles) and bus_err=0.
REQ-044 Protocol violation scenario: ext_rd_n and ext_wr_n fall together -> no mpu_en, bus_err=1, which stays 1 until reset.
REQ-045 Reset-in-flight scenario: reset asserted during RD_HOLD -> ext_data_oe=0 next cycle; with ext_rd_n still low after release, one new read is issued.

Source files
------------

// File: rtl/mpu_bus_adapter_if.sv
// Signal bundle between an 8-bit multiplexed-bus MCU and the 16-bit core access port.
// The adapter takes the slave view; the MCU/core side takes the master view.
interface mpu_bus_adapter_if;
   logic        ext_ale;
   logic        ext_rd_n;
   logic        ext_wr_n;
   logic [7:0]  ext_ad_in;
   logic [7:0]  ext_addr_hi;
   logic [7:0]  ext_data_out;
   logic        ext_data_oe;
   logic        mpu_en;
   logic        mpu_rd;
   logic        mpu_wr;
   logic [1:0]  mpu_be;
   logic [15:0] mpu_addr;
   logic [15:0] mpu_data_out;
   logic [15:0] mpu_data_in;
   logic        bus_err;

   modport slave (
      input  ext_ale, ext_rd_n, ext_wr_n, ext_ad_in, ext_addr_hi, mpu_data_in,
      output ext_data_out, ext_data_oe, mpu_en, mpu_rd, mpu_wr, mpu_be, mpu_addr,
             mpu_data_out, bus_err
   );

   modport master (
      output ext_ale, ext_rd_n, ext_wr_n, ext_ad_in, ext_addr_hi, mpu_data_in,
      input  ext_data_out, ext_data_oe, mpu_en, mpu_rd, mpu_wr, mpu_be, mpu_addr,
             mpu_data_out, bus_err
   );
endinterface

// File: rtl/mpu_bus_adapter.sv
// Bridges an asynchronous 8-bit multiplexed MCU bus onto a synchronous 16-bit core port:
// synchronises the MCU pins, latches the address and runs one core access per strobe.
module mpu_bus_adapter #(
   parameter int SYNC_STAGES = 2,
   parameter int RD_LATENCY  = 1
) (
   input  logic             clk,
   input  logic             reset,
   mpu_bus_adapter_if.slave bus
);
   localparam int               CNT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY - 1);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      RD_ISSUE   = 3'd1,
      RD_CAPTURE = 3'd2,
      RD_HOLD    = 3'd3,
      WR_SETTLE  = 3'd4,
      WR_ISSUE   = 3'd5,
      WR_DONE    = 3'd6
   } state_t;

   logic [SYNC_STAGES-1:0] ale_sync_q;
   logic [SYNC_STAGES-1:0] rd_sync_q;
   logic [SYNC_STAGES-1:0] wr_sync_q;
   logic [7:0]             ad_sync_q [SYNC_STAGES];
   logic [7:0]             hi_sync_q [SYNC_STAGES];

   logic       ale_s;
   logic       rd_s;
   logic       wr_s;
   logic [7:0] ad_s;
   logic [7:0] addr_hi_s;

   state_t           state_q,    state_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic [15:0]      addr_q,     addr_d;
   logic [15:0]      mpu_addr_q, mpu_addr_d;
   logic [1:0]       mpu_be_q,   mpu_be_d;
   logic [15:0]      wdata_q,    wdata_d;
   logic [7:0]       rdata_q,    rdata_d;
   logic             oe_q,       oe_d;
   logic             en_q,       en_d;
   logic             rd_q,       rd_d;
   logic             wr_q,       wr_d;
   logic             err_q,      err_d;
   logic             in_rd_state_s;
   logic             in_wr_state_s;

   // Equal-depth pipelines keep strobes, ALE and address/data bytes mutually aligned.
   always_ff @(posedge clk) begin
      if (reset) begin
         ale_sync_q <= '0;
         rd_sync_q  <= '1;
         wr_sync_q  <= '1;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            ad_sync_q[i] <= 8'h00;
            hi_sync_q[i] <= 8'h00;
         end
      end else begin
         ale_sync_q   <= {ale_sync_q[SYNC_STAGES-2:0], bus.ext_ale};
         rd_sync_q    <= {rd_sync_q[SYNC_STAGES-2:0], bus.ext_rd_n};
         wr_sync_q    <= {wr_sync_q[SYNC_STAGES-2:0], bus.ext_wr_n};
         ad_sync_q[0] <= bus.ext_ad_in;
         hi_sync_q[0] <= bus.ext_addr_hi;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            ad_sync_q[i] <= ad_sync_q[i-1];
            hi_sync_q[i] <= hi_sync_q[i-1];
         end
      end
   end

   assign ale_s     = ale_sync_q[SYNC_STAGES-1];
   assign rd_s      = rd_sync_q[SYNC_STAGES-1];
   assign wr_s      = wr_sync_q[SYNC_STAGES-1];
   assign ad_s      = ad_sync_q[SYNC_STAGES-1];
   assign addr_hi_s = hi_sync_q[SYNC_STAGES-1];

   always_comb begin
      addr_d = addr_q;
      if (ale_s) begin
         addr_d = {addr_hi_s, ad_s};
      end else begin
         addr_d = addr_q;
      end
   end

   always_comb begin
      in_rd_state_s = (state_q == RD_ISSUE) || (state_q == RD_CAPTURE) || (state_q == RD_HOLD);
      in_wr_state_s = (state_q == WR_SETTLE) || (state_q == WR_ISSUE) || (state_q == WR_DONE);
      err_d         = err_q;
      if ((state_q == IDLE) && !rd_s && !wr_s) begin
         err_d = 1'b1;
      end else if (in_rd_state_s && !wr_s) begin
         err_d = 1'b1;
      end else if (in_wr_state_s && !rd_s) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end
   end

   // Address and byte lanes only follow the latch in IDLE, so they freeze for the whole access.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mpu_addr_d = mpu_addr_q;
      mpu_be_d   = mpu_be_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      case (state_q)
         IDLE: begin
            mpu_addr_d = {1'b0, addr_q[15:1]};
            mpu_be_d   = addr_q[0] ? 2'b10 : 2'b01;
            cnt_d      = '0;
            if (!rd_s && !wr_s) begin
               state_d = IDLE;
            end else if (ale_s) begin
               state_d = IDLE;
            end else if (!rd_s) begin
               state_d = RD_ISSUE;
            end else if (!wr_s) begin
               state_d = WR_SETTLE;
            end else begin
               state_d = IDLE;
            end
         end
         RD_ISSUE: begin
            if (cnt_q == CNT_LAST) begin
               state_d = RD_CAPTURE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RD_CAPTURE: begin
            rdata_d = mpu_be_q[1] ? bus.mpu_data_in[15:8] : bus.mpu_data_in[7:0];
            state_d = RD_HOLD;
         end
         RD_HOLD: begin
            if (rd_s) begin
               state_d = IDLE;
            end else begin
               state_d = RD_HOLD;
            end
         end
         WR_SETTLE: begin
            wdata_d = {ad_s, ad_s};
            state_d = WR_ISSUE;
         end
         WR_ISSUE: begin
            state_d = WR_DONE;
         end
         WR_DONE: begin
            if (wr_s) begin
               state_d = IDLE;
            end else begin
               state_d = WR_DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Strobes and tristate enable are decoded from the next state so they register with it.
   always_comb begin
      rd_d = (state_d == RD_ISSUE);
      wr_d = (state_d == WR_ISSUE);
      en_d = rd_d || wr_d;
      oe_d = (state_d == RD_HOLD);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= 16'h0000;
         mpu_addr_q <= 16'h0000;
         mpu_be_q   <= 2'b00;
         wdata_q    <= 16'h0000;
         rdata_q    <= 8'h00;
         oe_q       <= 1'b0;
         en_q       <= 1'b0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         mpu_addr_q <= mpu_addr_d;
         mpu_be_q   <= mpu_be_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         oe_q       <= oe_d;
         en_q       <= en_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         err_q      <= err_d;
      end
   end

   assign bus.ext_data_out = rdata_q;
   assign bus.ext_data_oe  = oe_q;
   assign bus.mpu_en       = en_q;
   assign bus.mpu_rd       = rd_q;
   assign bus.mpu_wr       = wr_q;
   assign bus.mpu_be       = mpu_be_q;
   assign bus.mpu_addr     = mpu_addr_q;
   assign bus.mpu_data_out = wdata_q;
   assign bus.bus_err      = err_q;
endmodule

// File: tb/tb_mpu_bus_adapter.sv
// Self-checking bench for mpu_bus_adapter: directed vector table, random transactions
// against an arithmetic reference model, and hand sequences for error and reset cases.
module tb_mpu_bus_adapter;
   localparam int SYNC   = 2;
   localparam int LAT    = 1;
   localparam int OE_MAX = SYNC + LAT + 2;
   localparam int NV     = 7;
   localparam int NRAND  = 40;

   typedef struct {
      bit          wr;
      logic [15:0] a;
      logic [7:0]  d;
      logic [15:0] core;
      int          hold;
      logic [15:0] exp_addr;
      logic [1:0]  exp_be;
      logic [15:0] exp_data;
      logic [7:0]  exp_byte;
   } vec_t;

   logic clk = 1'b0;
   logic reset;

   mpu_bus_adapter_if bus_if();

   mpu_bus_adapter #(.SYNC_STAGES(SYNC), .RD_LATENCY(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          rd_total = 0;
   int          wr_total = 0;
   int          en_total = 0;
   int          both_total = 0;
   logic [15:0] cap_addr = 16'h0000;
   logic [1:0]  cap_be = 2'b00;
   logic [15:0] cap_data = 16'h0000;
   bit          exp_err = 1'b0;

   // Core-side monitor: counts access cycles and records the last access attributes.
   always @(negedge clk) begin
      if (bus_if.mpu_en === 1'b1) en_total <= en_total + 1;
      if (bus_if.mpu_rd === 1'b1 && bus_if.mpu_wr === 1'b1) both_total <= both_total + 1;
      if (bus_if.mpu_en === 1'b1 && bus_if.mpu_rd === 1'b1) begin
         rd_total <= rd_total + 1;
         cap_addr <= bus_if.mpu_addr;
         cap_be   <= bus_if.mpu_be;
      end
      if (bus_if.mpu_en === 1'b1 && bus_if.mpu_wr === 1'b1) begin
         wr_total <= wr_total + 1;
         cap_addr <= bus_if.mpu_addr;
         cap_be   <= bus_if.mpu_be;
         cap_data <= bus_if.mpu_data_out;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic do_txn(input string tag, input bit wr, input logic [15:0] a, input logic [7:0] d,
                         input logic [15:0] core, input int hold, input bit viol,
                         input logic [15:0] ea, input logic [1:0] ebe, input logic [15:0] edata,
                         input logic [7:0] ebyte);
      int r0, w0, e0, first_oe;
      bus_if.ext_ale     = 1'b1;
      bus_if.ext_ad_in   = a[7:0];
      bus_if.ext_addr_hi = a[15:8];
      tick();
      tick();
      bus_if.ext_ale = 1'b0;
      tick();
      bus_if.ext_ad_in   = d;
      bus_if.mpu_data_in = core;
      r0       = rd_total;
      w0       = wr_total;
      e0       = en_total;
      first_oe = 0;
      if (wr) bus_if.ext_wr_n = 1'b0;
      else    bus_if.ext_rd_n = 1'b0;
      for (int i = 1; i <= hold; i++) begin
         tick();
         if (viol && i == 6) begin
            if (wr) bus_if.ext_rd_n = 1'b0;
            else    bus_if.ext_wr_n = 1'b0;
         end
         if (viol && i == 8) begin
            if (wr) bus_if.ext_rd_n = 1'b1;
            else    bus_if.ext_wr_n = 1'b1;
         end
         if (!wr && bus_if.ext_data_oe === 1'b1 && first_oe == 0) first_oe = i;
      end
      chk({tag, ".addr_hold"}, 32'(bus_if.mpu_addr), 32'(ea));
      if (!wr) begin
         chk({tag, ".oe_in_hold"}, 32'(bus_if.ext_data_oe), 32'd1);
         chk({tag, ".rd_byte"}, 32'(bus_if.ext_data_out), 32'(ebyte));
         chk({tag, ".oe_latency_ok"}, 32'(first_oe >= 1 && first_oe <= OE_MAX), 32'd1);
         bus_if.ext_rd_n = 1'b1;
         repeat (SYNC) tick();
         chk({tag, ".oe_until_rise"}, 32'(bus_if.ext_data_oe), 32'd1);
         tick();
         chk({tag, ".oe_drop"}, 32'(bus_if.ext_data_oe), 32'd0);
         repeat (2) tick();
      end else begin
         bus_if.ext_wr_n = 1'b1;
         repeat (SYNC + 3) tick();
         chk({tag, ".wr_data"}, 32'(cap_data), 32'(edata));
      end
      chk({tag, ".rd_cycles"}, 32'(rd_total - r0), wr ? 32'd0 : 32'(LAT));
      chk({tag, ".wr_cycles"}, 32'(wr_total - w0), wr ? 32'd1 : 32'd0);
      chk({tag, ".en_cycles"}, 32'(en_total - e0), wr ? 32'd1 : 32'(LAT));
      chk({tag, ".acc_addr"}, 32'(cap_addr), 32'(ea));
      chk({tag, ".acc_be"}, 32'(cap_be), 32'(ebe));
      chk({tag, ".bus_err"}, 32'(bus_if.bus_err), 32'(exp_err));
   endtask

   initial begin
      vec_t        vecs [NV];
      bit          rwr, rviol;
      logic [15:0] ra, rcore, rea, redata;
      logic [7:0]  rd8, rbyte;
      logic [1:0]  rbe;
      int          rhold, e0, r0, first_oe;

      vecs[0] = '{1'b1, 16'h1235, 8'hA5, 16'h0000, 8,  16'h091A, 2'b10, 16'hA5A5, 8'h00};
      vecs[1] = '{1'b0, 16'h2000, 8'h00, 16'hBEEF, 8,  16'h1000, 2'b01, 16'h0000, 8'hEF};
      vecs[2] = '{1'b0, 16'h2001, 8'h00, 16'hBEEF, 8,  16'h1000, 2'b10, 16'h0000, 8'hBE};
      vecs[3] = '{1'b0, 16'h2000, 8'h00, 16'hBEEF, 50, 16'h1000, 2'b01, 16'h0000, 8'hEF};
      vecs[4] = '{1'b1, 16'hFFFE, 8'h3C, 16'h0000, 12, 16'h7FFF, 2'b01, 16'h3C3C, 8'h00};
      vecs[5] = '{1'b1, 16'h0001, 8'h00, 16'h0000, 4,  16'h0000, 2'b10, 16'h0000, 8'h00};
      vecs[6] = '{1'b0, 16'hFFFF, 8'h00, 16'h5A69, 6,  16'h7FFF, 2'b10, 16'h0000, 8'h5A};

      bus_if.ext_ale     = 1'b0;
      bus_if.ext_rd_n    = 1'b1;
      bus_if.ext_wr_n    = 1'b1;
      bus_if.ext_ad_in   = 8'h00;
      bus_if.ext_addr_hi = 8'h00;
      bus_if.mpu_data_in = 16'h0000;
      reset = 1'b1;
      repeat (3) tick();
      chk("reset.oe", 32'(bus_if.ext_data_oe), 32'd0);
      chk("reset.ext_data", 32'(bus_if.ext_data_out), 32'd0);
      chk("reset.strobes", 32'({bus_if.mpu_en, bus_if.mpu_rd, bus_if.mpu_wr}), 32'd0);
      chk("reset.be", 32'(bus_if.mpu_be), 32'd0);
      chk("reset.addr", 32'(bus_if.mpu_addr), 32'd0);
      chk("reset.wdata", 32'(bus_if.mpu_data_out), 32'd0);
      chk("reset.bus_err", 32'(bus_if.bus_err), 32'd0);
      reset = 1'b0;
      repeat (3) tick();

      for (int k = 0; k < NV; k++) begin
         do_txn($sformatf("vec%0d", k), vecs[k].wr, vecs[k].a, vecs[k].d, vecs[k].core,
                vecs[k].hold, 1'b0, vecs[k].exp_addr, vecs[k].exp_be, vecs[k].exp_data,
                vecs[k].exp_byte);
      end

      for (int n = 0; n < NRAND; n++) begin
         rwr   = 1'($urandom_range(0, 1));
         ra    = 16'($urandom);
         rd8   = 8'($urandom);
         rcore = 16'($urandom);
         rhold = rwr ? int'($urandom_range(4, 20)) : int'($urandom_range(6, 20));
         rviol = (rhold >= 10) && ($urandom_range(0, 7) == 0);
         rea    = 16'(ra / 2);
         rbe    = (ra % 2 == 1) ? 2'd2 : 2'd1;
         redata = 16'(rd8 * 257);
         rbyte  = 8'((rcore >> (8 * (ra % 2))) & 16'h00FF);
         if (rviol) exp_err = 1'b1;
         do_txn($sformatf("rnd%0d", n), rwr, ra, rd8, rcore, rhold, rviol, rea, rbe, redata, rbyte);
      end

      // Both strobes falling together must raise a sticky error with no core access.
      reset = 1'b1;
      repeat (2) tick();
      reset   = 1'b0;
      exp_err = 1'b0;
      tick();
      chk("post_reset.bus_err", 32'(bus_if.bus_err), 32'd0);
      e0 = en_total;
      bus_if.ext_rd_n = 1'b0;
      bus_if.ext_wr_n = 1'b0;
      repeat (10) tick();
      chk("both_low.no_access", 32'(en_total - e0), 32'd0);
      chk("both_low.bus_err", 32'(bus_if.bus_err), 32'd1);
      bus_if.ext_rd_n = 1'b1;
      bus_if.ext_wr_n = 1'b1;
      repeat (5) tick();
      chk("both_low.no_access_after", 32'(en_total - e0), 32'd0);
      chk("both_low.sticky", 32'(bus_if.bus_err), 32'd1);
      exp_err = 1'b1;
      do_txn("after_err", 1'b0, 16'h2000, 8'h00, 16'hBEEF, 8, 1'b0, 16'h1000, 2'b01, 16'h0000, 8'hEF);

      // Reset during RD_HOLD with the read strobe still low afterwards.
      bus_if.ext_ale     = 1'b1;
      bus_if.ext_ad_in   = 8'h00;
      bus_if.ext_addr_hi = 8'h20;
      repeat (2) tick();
      bus_if.ext_ale = 1'b0;
      tick();
      bus_if.mpu_data_in = 16'hBEEF;
      bus_if.ext_rd_n    = 1'b0;
      repeat (7) tick();
      chk("rif.oe_before", 32'(bus_if.ext_data_oe), 32'd1);
      reset = 1'b1;
      tick();
      chk("rif.oe_reset", 32'(bus_if.ext_data_oe), 32'd0);
      chk("rif.en_reset", 32'(bus_if.mpu_en), 32'd0);
      chk("rif.err_reset", 32'(bus_if.bus_err), 32'd0);
      r0 = rd_total;
      tick();
      reset   = 1'b0;
      exp_err = 1'b0;
      first_oe = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (bus_if.ext_data_oe === 1'b1 && first_oe == 0) first_oe = i;
      end
      chk("rif.new_read_cycles", 32'(rd_total - r0), 32'(LAT));
      chk("rif.oe_new", 32'(bus_if.ext_data_oe), 32'd1);
      chk("rif.byte", 32'(bus_if.ext_data_out), 32'hEF);
      chk("rif.oe_latency_ok", 32'(first_oe >= 1 && first_oe <= OE_MAX + SYNC), 32'd1);
      bus_if.ext_rd_n = 1'b1;
      repeat (6) tick();
      chk("rif.oe_end", 32'(bus_if.ext_data_oe), 32'd0);
      chk("rif.single_read", 32'(rd_total - r0), 32'(LAT));
      chk("final.bus_err", 32'(bus_if.bus_err), 32'd0);
      chk("final.no_rd_wr_overlap", 32'(both_total), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
